// File: rtl/mult_arbiter_1_if.sv
// Requester, response and multiplier signals of the shared-multiplier arbiter.
// master = requesters plus the multiplier model; slave = the arbiter itself.
interface mult_arbiter_1_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [9*NREQ-1:0] req_a;
    logic [9*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [16:0]       rsp_prdct;
    logic              rsp_err;
    logic [8:0]        mul_a;
    logic [8:0]        mul_b;
    logic              mul_en;
    logic [16:0]       mul_prdct;
    logic              mul_rdy;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    modport master (
        output req_valid, req_a, req_b, mul_prdct, mul_rdy,
        input  req_ready, rsp_valid, rsp_prdct, rsp_err,
               mul_a, mul_b, mul_en, busy, grant_id
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_prdct, mul_rdy,
        output req_ready, rsp_valid, rsp_prdct, rsp_err,
               mul_a, mul_b, mul_en, busy, grant_id
    );
endinterface

// File: rtl/mult_arbiter_1.sv
// Round-robin arbiter sharing one sign-magnitude multiplier among NREQ requesters.
// Latency: accept T, ISSUE T+1, WAIT from T+2, response one cycle after mul_rdy or timeout.
// Backpressure: req_ready only in IDLE; a single operation outstanding, no queueing.
module mult_arbiter_1 #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input logic             clk,
    input logic             rst_n,
    mult_arbiter_1_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic [7:0]      wd_cnt;
    logic [8:0]      mul_a;
    logic [8:0]      mul_b;
    logic            mul_en;
    logic            busy;
    logic [NREQ-1:0] rsp_valid;
    logic [16:0]     rsp_prdct;
    logic            rsp_err;

    logic            pick_vld;
    logic [IDW-1:0]  pick_id;
    logic            timeout_hit;

    logic [8:0]      op_a [NREQ];
    logic [8:0]      op_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = bus.req_a[9*g +: 9];
        assign op_b[g] = bus.req_b[9*g +: 9];
    end

    // Scan starts at rr_ptr and wraps, so the last winner is visited last.
    always_comb begin
        logic [IDW-1:0] idx;
        idx      = '0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!pick_vld && bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

    assign timeout_hit = (wd_cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pick_vld) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (bus.mul_rdy || timeout_hit) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            wd_cnt    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_en    <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= '0;
            rsp_prdct <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        mul_a    <= op_a[pick_id];
                        mul_b    <= op_b[pick_id];
                        grant_id <= pick_id;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    // A ready pulse in the timeout cycle still counts as a normal completion.
                    if (bus.mul_rdy) begin
                        rsp_prdct <= bus.mul_prdct;
                        rsp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_prdct <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                end
                default: ;
            endcase

            // Registered outputs follow the state being entered.
            busy      <= (state_nxt != IDLE);
            mul_en    <= (state_nxt == ISSUE) || (state_nxt == WAIT);
            rsp_valid <= (state_nxt == RESP) ? (NREQ'(1) << grant_id) : '0;
        end
    end

    assign bus.req_ready = (state == IDLE && pick_vld) ? (NREQ'(1) << pick_id) : '0;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_prdct = rsp_prdct;
    assign bus.rsp_err   = rsp_err;
    assign bus.mul_a     = mul_a;
    assign bus.mul_b     = mul_b;
    assign bus.mul_en    = mul_en;
    assign bus.busy      = busy;
    assign bus.grant_id  = grant_id;

endmodule

// File: tb/tb_mult_arbiter_1.sv
// Directed bench for mult_arbiter_1: vector table of operations plus reset/stray-pulse sequences.
module tb_mult_arbiter_1;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    mult_arbiter_1_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mult_arbiter_1 #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  vmask;
        logic        hold;
        int          id;
        logic [8:0]  a;
        logic [8:0]  b;
        int          d;      // cycle after acceptance carrying mul_rdy, -1 = never
        logic [16:0] p;
        logic        err;
        logic        stray;  // extra mul_rdy in the IDLE and ISSUE cycles
    } vec_t;

    vec_t tab [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic op(input vec_t v);
        int         t0;
        int         lat;
        bit         got;
        bit         stable;
        bit         quiet;
        bit         seen;
        logic [3:0] oh;
        oh = 4'(1) << v.id;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[9*i +: 9] = 9'(16 * i + 1);
            bus.req_b[9*i +: 9] = 9'(16 * i + 2);
        end
        bus.req_a[9*v.id +: 9] = v.a;
        bus.req_b[9*v.id +: 9] = v.b;
        bus.req_valid = v.vmask;
        bus.mul_rdy   = v.stray;
        bus.mul_prdct = ~v.p;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept", 32'(got), 1);
        chk("req_ready", 32'(bus.req_ready), 32'(oh));
        chk("busy_at_accept", 32'(bus.busy), 0);
        t0 = cyc;
        @(posedge clk); #1;
        if (!v.hold) bus.req_valid = v.vmask & ~oh;
        stable = 1; quiet = 1; seen = 0; lat = 0;
        for (int k = 1; k < 200; k++) begin
            bus.mul_rdy   = (v.stray && k == 1) || (v.d == k);
            bus.mul_prdct = (v.d == k) ? v.p : ~v.p;
            @(negedge clk);
            if (bus.mul_a !== v.a || bus.mul_b !== v.b) stable = 0;
            if (bus.rsp_valid != 0) begin
                seen = 1;
                lat  = cyc - t0;
                break;
            end
            if (bus.mul_en !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) quiet = 0;
            @(posedge clk); #1;
        end
        chk("rsp_seen", 32'(seen), 1);
        chk("latency", 32'(lat), 32'((v.d >= 0) ? v.d + 1 : TIMEOUT + 2));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        chk("rsp_prdct", 32'(bus.rsp_prdct), 32'(v.p));
        chk("rsp_err", 32'(bus.rsp_err), 32'(v.err));
        chk("grant_id", 32'(bus.grant_id), 32'(v.id));
        chk("mul_en_in_resp", 32'(bus.mul_en), 0);
        chk("operands_stable", 32'(stable), 1);
        chk("busy_en_during_op", 32'(quiet), 1);
        @(posedge clk); #1;
        bus.mul_rdy = 1'b0;
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        bit rsp_none;
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.mul_prdct = '0;
        bus.mul_rdy   = 1'b0;

        // Round-robin with everyone requesting, then single/timeout/race/sign cases.
        tab[0] = '{4'b1111, 1'b1, 0, 9'h0A1, 9'h1B1, 4, 17'h00100, 1'b0, 1'b0};
        tab[1] = '{4'b1111, 1'b1, 1, 9'h0A2, 9'h1B2, 4, 17'h00101, 1'b0, 1'b0};
        tab[2] = '{4'b1111, 1'b1, 2, 9'h0A3, 9'h1B3, 4, 17'h00102, 1'b0, 1'b0};
        tab[3] = '{4'b1111, 1'b1, 3, 9'h0A4, 9'h1B4, 4, 17'h00103, 1'b0, 1'b0};
        tab[4] = '{4'b1111, 1'b1, 0, 9'h0A5, 9'h1B5, 4, 17'h00104, 1'b0, 1'b0};
        tab[5] = '{4'b0001, 1'b0, 0, 9'h105, 9'h003, 9, 17'h1000F, 1'b0, 1'b0};
        tab[6] = '{4'b0110, 1'b0, 1, 9'h0FF, 9'h1FF, -1, 17'h00000, 1'b1, 1'b0};
        tab[7] = '{4'b1111, 1'b0, 2, 9'h055, 9'h0AA, TIMEOUT + 1, 17'h0ABCD, 1'b0, 1'b1};
        tab[8] = '{4'b1000, 1'b0, 3, 9'h180, 9'h17F, 2, 17'h00000, 1'b0, 1'b0};
        tab[9] = '{4'b1100, 1'b0, 2, 9'h1C3, 9'h03C, 3, 17'h1FFFF, 1'b0, 1'b0};

        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_mul_en", 32'(bus.mul_en), 0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_req_ready", 32'(bus.req_ready), 0);
        chk("reset_mul_ab", 32'({bus.mul_a, bus.mul_b}), 0);
        chk("reset_grant_id", 32'(bus.grant_id), 0);
        chk("reset_rsp", 32'({bus.rsp_err, bus.rsp_prdct}), 0);
        rst_n = 1'b1;

        // Stray ready pulses while idle must not start anything.
        rsp_none = 1;
        @(posedge clk); #1;
        bus.mul_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0 || bus.mul_en !== 1'b0) rsp_none = 0;
            @(posedge clk); #1;
        end
        bus.mul_rdy = 1'b0;
        chk("stray_idle_quiet", 32'(rsp_none), 1);

        for (int i = 0; i < 10; i++) op(tab[i]);

        // Reset in WAIT: rr_ptr is 3 now, so requester 2 wins from mask 0100.
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("pre_reset_ready", 32'(bus.req_ready), 32'(4'b0100));
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(bus.busy), 1);
        #1 rst_n = 1'b0;
        bus.mul_rdy = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mul_en", 32'(bus.mul_en), 0);
        chk("rst_mul_ab", 32'({bus.mul_a, bus.mul_b}), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_rsp", 32'({bus.rsp_err, bus.rsp_prdct}), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        rsp_none = 1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) rsp_none = 0;
        end
        bus.mul_rdy = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) rsp_none = 0;
        end
        chk("no_rsp_after_reset", 32'(rsp_none), 1);
        @(posedge clk); #1;
        op('{4'b1111, 1'b0, 0, 9'h111, 9'h122, 2, 17'h12345, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
